// File: rtl/neopixel_tx.sv
// NeoPixel (WS2812-style) serial transmitter: 5-pixel GRB color store, 120-bit frame, latch gap.
// Optional NEOPIXEL_CLEAR_AFTER_SEND_EN clears the color store when the last data bit completes.
module neopixel_tx #(
  parameter int unsigned T0H    = 18,
  parameter int unsigned T1H    = 35,
  parameter int unsigned TBIT   = 63,
  parameter int unsigned TRESET = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       load_color,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send,
  output logic       begin_send,
  output logic       done_send,
  output logic       done_wait
);

  localparam int unsigned NBITS = 120;
  localparam int unsigned BW    = 7;
  localparam int unsigned CMAX  = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int unsigned CW    = $clog2(CMAX + 1);

`ifdef NEOPIXEL_CLEAR_AFTER_SEND_EN
  localparam bit CLEAR_AFTER_SEND = 1'b1;
`else
  localparam bit CLEAR_AFTER_SEND = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cyc, cyc_n;
  logic [BW-1:0]   bit_idx, bit_n;
  // Store held in transmit order: frame bit k lives at frame[NBITS-1-k].
  logic [NBITS-1:0] frame;

  logic          wr_en;
  logic [1:0]    slot;
  logic [BW-1:0] wr_pos;
  logic          clr_en;
  logic          bit_val;
  logic          neo_n, begin_n, done_send_n, done_wait_n, ready_n;

  // Write decode: byte slot within a pixel is green, red, blue.
  always_comb begin
    wr_en  = (state == IDLE) && load_color && (pixel_index <= 3'd4) && (color_index != 2'b11);
    slot   = 2'd2;
    if (color_index == 2'b01)      slot = 2'd0;
    else if (color_index == 2'b00) slot = 2'd1;
    wr_pos = BW'(NBITS - 1) - (BW'(pixel_index) * BW'(24) + BW'(slot) * BW'(8));
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    bit_n       = bit_idx;
    begin_n     = 1'b0;
    done_send_n = 1'b0;
    clr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (send_it) begin
          state_n = SEND;
          cyc_n   = '0;
          bit_n   = '0;
          begin_n = 1'b1;
        end
      end
      SEND: begin
        if (cyc == CW'(TBIT - 1)) begin
          cyc_n = '0;
          if (bit_idx == BW'(NBITS - 1)) begin
            state_n     = LATCH;
            done_send_n = 1'b1;
            clr_en      = 1'b1;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      LATCH: begin
        if (cyc == CW'(TRESET - 1)) begin
          state_n = IDLE;
          cyc_n   = '0;
          bit_n   = '0;
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    done_wait_n = (state_n == LATCH) && (cyc_n == CW'(TRESET - 1));
    // The bit value is first needed at cycle T0H, so a same-edge write is already visible.
    bit_val     = frame[BW'(NBITS - 1) - bit_n];
    neo_n       = (state_n == SEND) && (cyc_n < (bit_val ? CW'(T1H) : CW'(T0H)));
    ready_n     = (state_n == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cyc           <= '0;
      bit_idx       <= '0;
      frame         <= '0;
      neo_data      <= 1'b0;
      begin_send    <= 1'b0;
      done_send     <= 1'b0;
      done_wait     <= 1'b0;
      ready_to_load <= 1'b1;
      ready_to_send <= 1'b1;
    end else begin
      state         <= state_n;
      cyc           <= cyc_n;
      bit_idx       <= bit_n;
      neo_data      <= neo_n;
      begin_send    <= begin_n;
      done_send     <= done_send_n;
      done_wait     <= done_wait_n;
      ready_to_load <= ready_n;
      ready_to_send <= ready_n;
      if (wr_en) begin
        frame[wr_pos -: 8] <= color_level;
      end else if (CLEAR_AFTER_SEND && clr_en) begin
        frame <= '0;
      end
    end
  end

endmodule

// File: tb/tb_neopixel_tx.sv
// Directed self-checking bench for neopixel_tx: frame timing, bit encoding, write filtering, aborts.
module tb_neopixel_tx;

  localparam int unsigned T0H    = 18;
  localparam int unsigned T1H    = 35;
  localparam int unsigned TBIT   = 63;
  localparam int unsigned TRESET = 2500;
  localparam int unsigned NBITS  = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] pixel_index = '0;
  logic [1:0] color_index = '0;
  logic [7:0] color_level = '0;
  logic       load_color = 1'b0;
  logic       send_it = 1'b0;
  logic       neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] model [5][3];

  neopixel_tx #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) dut (
    .clock(clock), .reset(reset), .pixel_index(pixel_index), .color_index(color_index),
    .color_level(color_level), .load_color(load_color), .send_it(send_it),
    .neo_data(neo_data), .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
    .begin_send(begin_send), .done_send(done_send), .done_wait(done_wait)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < 5; p++)
      for (int c = 0; c < 3; c++)
        model[p][c] = 8'h00;
  endtask

  // Expected bit k of the frame: pixel k/24, bytes G,R,B, MSB first.
  function automatic logic [NBITS-1:0] model_bits();
    logic [NBITS-1:0] e;
    logic [7:0] byt;
    int ch;
    e = '0;
    for (int p = 0; p < 5; p++)
      for (int s = 0; s < 3; s++) begin
        ch  = (s == 0) ? 1 : ((s == 1) ? 0 : 2);
        byt = model[p][ch];
        for (int b = 0; b < 8; b++) e[p*24 + s*8 + b] = byt[7-b];
      end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_model();
  endtask

  task automatic load(input int p, input int c, input logic [7:0] v);
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = v;
    load_color  = 1'b1;
    @(negedge clock);
    load_color  = 1'b0;
    if (p <= 4 && c != 3) model[p][c] = v;
  endtask

  // Caller may pre-drive a load for the same cycle as send_it; model must already reflect it.
  task automatic run_frame(input string tag, input bit mid_poke);
    logic [NBITS-1:0] e;
    int hi, ds, glitch, cnt, nh;
    e = model_bits();
    check_eq({tag, "_rdy_send_idle"}, int'(ready_to_send), 1);
    check_eq({tag, "_rdy_load_idle"}, int'(ready_to_load), 1);
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    load_color = 1'b0;
    check_eq({tag, "_begin_send"}, int'(begin_send), 1);
    check_eq({tag, "_first_high"}, int'(neo_data), 1);
    check_eq({tag, "_rdy_load_send"}, int'(ready_to_load), 0);
    ds = 0;
    glitch = 0;
    for (int k = 0; k < int'(NBITS); k++) begin
      hi = 0;
      for (int c = 0; c < int'(TBIT); c++) begin
        if (!(k == 0 && c == 0)) begin
          @(negedge clock);
          load_color = 1'b0;
          send_it = 1'b0;
          ds += int'(done_send) + int'(done_wait) + int'(begin_send);
        end
        if (neo_data) begin
          if (hi != c) glitch++;
          hi++;
        end
        if (mid_poke && k == 60 && c == 5) begin
          check_eq({tag, "_mid_rdy_load"}, int'(ready_to_load), 0);
          check_eq({tag, "_mid_rdy_send"}, int'(ready_to_send), 0);
          pixel_index = 3'd0;
          color_index = 2'b01;
          color_level = 8'hFF;
          load_color  = 1'b1;
          send_it     = 1'b1;
        end
      end
      check_eq($sformatf("%s_b%0d_high", tag, k), hi, e[k] ? int'(T1H) : int'(T0H));
    end
    check_eq({tag, "_glitches"}, glitch, 0);
    check_eq({tag, "_early_pulses"}, ds, 0);
    @(negedge clock);
    check_eq({tag, "_done_send"}, int'(done_send), 1);
    check_eq({tag, "_latch_low"}, int'(neo_data), 0);
    cnt = 1;
    nh = 0;
    ds = 0;
    while (!done_wait && cnt < int'(TRESET) + 100) begin
      @(negedge clock);
      cnt++;
      if (neo_data) nh++;
      if (done_send) ds++;
    end
    check_eq({tag, "_latch_len"}, cnt, int'(TRESET));
    check_eq({tag, "_latch_high"}, nh, 0);
    check_eq({tag, "_done_send_len"}, ds, 0);
    @(negedge clock);
    check_eq({tag, "_done_wait_len"}, int'(done_wait), 0);
    check_eq({tag, "_rdy_send_after"}, int'(ready_to_send), 1);
    check_eq({tag, "_rdy_load_after"}, int'(ready_to_load), 1);
`ifdef NEOPIXEL_CLEAR_AFTER_SEND_EN
    clear_model();
`endif
  endtask

  task automatic abort_frame();
    int pulses, nh;
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    repeat (60 * TBIT + 10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("abort_neo", int'(neo_data), 0);
    check_eq("abort_rdy_send", int'(ready_to_send), 1);
    check_eq("abort_rdy_load", int'(ready_to_load), 1);
    check_eq("abort_done_send", int'(done_send), 0);
    reset = 1'b1;
    clear_model();
    pulses = 0;
    nh = 0;
    repeat (300) begin
      @(negedge clock);
      pulses += int'(done_send) + int'(done_wait) + int'(begin_send);
      if (neo_data) nh++;
    end
    check_eq("abort_pulses", pulses, 0);
    check_eq("abort_line_low", nh, 0);
    check_eq("abort_rdy_send_after", int'(ready_to_send), 1);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clock);
    check_eq("rst_neo", int'(neo_data), 0);
    check_eq("rst_begin", int'(begin_send), 0);
    check_eq("rst_done_send", int'(done_send), 0);
    check_eq("rst_done_wait", int'(done_wait), 0);
    check_eq("rst_rdy_load", int'(ready_to_load), 1);
    check_eq("rst_rdy_send", int'(ready_to_send), 1);
    reset = 1'b1;
    @(negedge clock);

    run_frame("empty", 1'b0);

    load(0, 1, 8'h80);
    load(4, 2, 8'h01);
    run_frame("two_ones", 1'b0);

    do_reset();
    load(5, 0, 8'hAA);
    load(1, 3, 8'h55);
    load(7, 2, 8'h33);
    run_frame("invalid", 1'b0);

    do_reset();
    pixel_index = 3'd2;
    color_index = 2'b00;
    color_level = 8'hFF;
    load_color  = 1'b1;
    model[2][0] = 8'hFF;
    run_frame("same_cycle", 1'b1);

    run_frame("resend", 1'b0);

    abort_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_tx.md
NEOPIXEL_TX -- requirements
Module: neopixel_tx

Interface
REQ-001 The block SHALL have parameter T0H, default 18, meaning the clock count that neo_data is high for a 0 bit.
REQ-002 The block SHALL have parameter T1H, default 35, meaning the clock count that neo_data is high for a 1 bit.
REQ-003 The block SHALL have parameter TBIT, default 63, meaning the total clock count of one bit period; TBIT > T1H > T0H.
REQ-004 The block SHALL have parameter TRESET, default 2500, meaning the clock count of the low latch gap after a frame.
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 pixel_index  input  3  pixel to write, valid 0-4.
REQ-008 color_index  input  2  channel to write: 00 red, 01 green, 10 blue, 11 ignored.
REQ-009 color_level  input  8  channel intensity to store.
REQ-010 load_color  input  1  write strobe, sampled each cycle.
REQ-011 send_it  input  1  start-frame strobe, sampled each cycle.
REQ-012 neo_data  output  1  serial NeoPixel line.
REQ-013 ready_to_load  output  1  high while writes are accepted.
REQ-014 ready_to_send  output  1  high while a frame start is accepted.
REQ-015 begin_send  output  1  one-cycle pulse on the first cycle of a frame.
REQ-016 done_send  output  1  one-cycle pulse when the last data bit period ends.
REQ-017 done_wait  output  1  one-cycle pulse when the latch gap ends.

Function
REQ-018 The color store SHALL be 5 pixels x 3 channels x 8 bits; the frame SHALL be 120 bits.
REQ-019 The frame SHALL be sent pixel 0 to pixel 4, each pixel green then red then blue, MSB first.
REQ-020 The FSM SHALL have states IDLE, SEND and LATCH.
REQ-021 In IDLE, ready_to_load and ready_to_send SHALL be 1; in SEND and LATCH both SHALL be 0.
REQ-022 In IDLE with load_color=1, pixel_index<=4 and color_index!=11, the addressed byte SHALL be written at that edge; any other combination SHALL be ignored with no store change.
REQ-023 load_color outside IDLE SHALL be ignored.
REQ-024 In IDLE with send_it=1, the FSM SHALL go to SEND at that edge; neo_data SHALL rise on the next cycle, with begin_send=1 for that cycle.
REQ-025 If load_color and send_it are both asserted in IDLE, the write SHALL occur and the frame SHALL include the written value.
REQ-026 send_it outside IDLE SHALL be ignored.
REQ-027 Each bit SHALL occupy exactly TBIT cycles: neo_data high for T1H cycles for a 1 bit or T0H cycles for a 0 bit, then low for the remainder.
REQ-028 Bits SHALL be back-to-back with no gap; the bit counter SHALL run 0-119 and the per-bit cycle counter 0 to TBIT-1.
REQ-029 After bit 119's final cycle, the FSM SHALL go to LATCH, with done_send=1 for exactly one cycle, on the first LATCH cycle.
REQ-030 In LATCH, neo_data SHALL be 0 for TRESET cycles; done_wait SHALL be 1 on the final LATCH cycle, then the FSM SHALL return to IDLE.
REQ-031 The store SHALL be retained across frames unless cleared per REQ-035.

Reset
REQ-032 With reset=0 at a rising edge: state IDLE; all store bytes 0x00; all counters 0.
REQ-033 During and after reset: neo_data=0, begin_send=0, done_send=0, done_wait=0, ready_to_load=1, ready_to_send=1.
REQ-034 Reset mid-SEND or mid-LATCH SHALL abort the frame and produce no done_send or done_wait pulse.

Configuration
REQ-035 With NEOPIXEL_CLEAR_AFTER_SEND_EN defined, all store bytes SHALL be cleared to 0x00 on the done_send cycle; without it, the store SHALL be unchanged by sending.

Verification
REQ-036 Reset, then send_it with no loads -> 120 bits, each high 18 and low 45 cycles; done_send after 7560 cycles; done_wait 2500 cycles later.
REQ-037 Load pixel 0 green 0x80, pixel 4 blue 0x01, then send -> only bit 0 and bit 119 have a 35-cycle high; all other bits have an 18-cycle high.
REQ-038 load_color with pixel_index=5 or color_index=11, then send -> all bits are 0 bits.
REQ-039 load_color and send_it asserted in the same IDLE cycle (pixel 2 red 0xFF) -> bits 56-63 are 1 bits; a mid-SEND load or send_it is ignored and ready_to_load=0.
REQ-040 Reset pulsed at bit 60 -> neo_data=0 next cycle, no done pulses, ready_to_send=1; with the macro defined, a second frame after a completed send is all 0 bits.
